int_msg_bank_buffer: RTL and testbench
======================================

Name: int_msg_bank_buffer

Overview:
- Multi-bank ping-pong store for channel intrinsic LLRs, sitting between the channel LLR loader and the LDPC decoder core.
- The loader streams one frame sequentially into a free bank while the decoder randomly reads a previously completed frame.
- Banks rotate round-robin, with per-bank state tracking and valid/ready load and acquire/release decode handshakes.
- Generalises the fixed two-bank intrinsic RAM to N banks, with internal addressing, frame bookkeeping and input quantisation.

Parameters:
- DATA_WIDTH, 5, stored LLR width (signed two's complement).
- IN_WIDTH, 8, incoming channel LLR width (signed); must be >= DATA_WIDTH.
- ADDR_WIDTH, 8, bank address width.
- FRAME_LEN, 256, LLRs per frame; 2 <= FRAME_LEN <= 2^ADDR_WIDTH.
- NUM_BANKS, 2, number of banks, 2..4.
- BANK_W, derived, $clog2(NUM_BANKS).

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, loader LLR valid.
- in_ready, output, 1, buffer can accept an LLR.
- in_llr, input, IN_WIDTH, channel LLR.
- frame_loaded, output, 1, one-cycle pulse when the last LLR of a frame is written.
- dec_frame_avail, output, 1, at least one FULL bank is waiting.
- dec_acquire, input, 1, decoder claims the oldest FULL bank (pulse).
- dec_active, output, 1, decoder currently owns a bank.
- dec_bank, output, BANK_W, index of the owned bank.
- dec_release, input, 1, decoder returns its bank (pulse).
- dec_rd_en, input, 1, read request.
- dec_rd_addr, input, ADDR_WIDTH, read address.
- dec_rd_data, output, DATA_WIDTH, read data.
- dec_rd_valid, output, 1, dec_rd_data valid.
- full_count, output, BANK_W+1, number of banks in FULL state.

Behaviour:
- Storage: NUM_BANKS single-port synchronous RAMs, each FRAME_LEN x DATA_WIDTH.
- Per-bank state machine:
  - EMPTY -> FILLING on the first accepted LLR.
  - FILLING -> FULL on the accepted LLR at address FRAME_LEN-1.
  - FULL -> DECODING on an acquire.
  - DECODING -> EMPTY on a release.
- Pointers: wr_bank and rd_bank, each advancing modulo NUM_BANKS. wr_bank advances on frame completion; rd_bank advances on acquire.
- Load handshake:
  - in_ready = 1 when bank[wr_bank] is EMPTY or FILLING.
  - Transfer occurs when in_valid && in_ready.
  - Each transfer writes to address wr_addr, then wr_addr increments; it wraps to 0 at FRAME_LEN-1.
  - in_ready drops the cycle after the last write if the next bank is not EMPTY.
- frame_loaded pulses in the cycle after the last write completes.
- dec_frame_avail is 1 when bank[rd_bank] is FULL, and is registered from the state of the previous cycle.
  - Consequence: a frame completed in cycle t is acquirable no earlier than cycle t+1.
- Acquire:
  - Honoured only when dec_frame_avail=1 and dec_active=0; otherwise ignored with no state change.
  - When honoured, dec_active and dec_bank update on the next cycle.
- Release:
  - Honoured only when dec_active=1; otherwise ignored.
  - Release and acquire in the same cycle: release is processed first, then the acquire is evaluated against the updated state.
- Read:
  - When dec_rd_en=1 and dec_active=1: dec_rd_data and dec_rd_valid=1 are presented exactly 1 cycle later.
  - dec_rd_en with dec_active=0 produces dec_rd_valid=0.
  - Address >= FRAME_LEN returns 0 with dec_rd_valid=1.
  - dec_rd_data holds its last value when not valid.
- Port independence: load writes and decoder reads never target the same bank, so both ports may be active every cycle. The bank in DECODING is never writable.
- full_count tracks FULL banks. It changes by +1, -1 or 0 for a simultaneous completion and acquire.
- Reset (asynchronous, any time, including mid-frame or mid-decode):
  - All banks EMPTY; pointers, wr_addr and full_count = 0.
  - dec_active=0, dec_rd_valid=0, frame_loaded=0, dec_rd_data=0, dec_bank=0.
  - in_ready=1 on the first cycle after deassertion.
  - RAM contents are not cleared; a partial frame is discarded.

Optional Feature:
- Macro: INT_MSG_SAT_EN.
- Defined: in_llr is clamped symmetrically to [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)] before the write. For DATA_WIDTH=5 the range is -15..+15; -16 is never stored.
- Undefined: the low DATA_WIDTH bits of in_llr are stored unchanged (wrap), with no added logic.

Test Plan:
- Reset, then stream 256 LLRs of value (i mod 16) - 8 -> frame_loaded pulses once; dec_frame_avail=1 the next cycle; full_count=1; reading addr 10 after acquire returns 2 one cycle later with dec_rd_valid=1.
- NUM_BANKS=2: load 3 frames back-to-back without acquiring -> in_ready=0 after frame 2 and stays low; acquire then release -> in_ready=1 and frame 3 completes into bank 0.
- Concurrent: decoder reads bank 0 every cycle while frame 2 loads into bank 1 -> no read data corruption; dec_bank=0; frame 2 data is correct after rotation.
- Acquire while dec_active=1, and release while dec_active=0 -> both ignored; full_count and dec_bank unchanged; release and acquire in the same cycle -> dec_bank advances to the next FULL bank.
- With INT_MSG_SAT_EN: in_llr = +100, -128, -16, +7 -> stored +15, -15, -15, +7. Without it: stored +4, 0, -16, +7.
- Assert rst at LLR 100 of a frame and during decode -> all outputs reach their reset values asynchronously; the next full frame loads into bank 0 and reads back correctly.

Source files
------------

// File: rtl/int_msg_bank_buffer.sv
// int_msg_bank_buffer
//   N-bank ping-pong store for channel intrinsic LLRs. The loader streams a
//   frame sequentially into the current write bank while the decoder owns a
//   previously completed bank for random reads. Banks rotate round-robin and
//   each bank walks EMPTY -> FILLING -> FULL -> DECODING -> EMPTY.
//
//   Optional build macro: INT_MSG_SAT_EN
//     defined   : incoming LLRs are clamped symmetrically to
//                 +/-(2^(DATA_WIDTH-1)-1) before storage
//     undefined : the low DATA_WIDTH bits are stored unchanged (wrap)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready loader handshake, in_llr carries the channel LLR
//   frame_loaded      one-cycle pulse after the last LLR of a frame is written
//   dec_frame_avail   the oldest pending bank is FULL (registered)
//   dec_acquire       claim the oldest FULL bank (pulse)
//   dec_release       return the owned bank (pulse)
//   dec_active        decoder owns a bank; dec_bank is its index
//   dec_rd_en/addr    read request; dec_rd_data/dec_rd_valid one cycle later
//   full_count        number of banks currently FULL
module int_msg_bank_buffer #(
  parameter int DATA_WIDTH = 5,
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_llr,
  output logic                  frame_loaded,
  output logic                  dec_frame_avail,
  input  logic                  dec_acquire,
  output logic                  dec_active,
  output logic [BANK_W-1:0]     dec_bank,
  input  logic                  dec_release,
  input  logic                  dec_rd_en,
  input  logic [ADDR_WIDTH-1:0] dec_rd_addr,
  output logic [DATA_WIDTH-1:0] dec_rd_data,
  output logic                  dec_rd_valid,
  output logic [BANK_W:0]       full_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_DECODING
  } bank_state_t;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][FRAME_LEN];

  bank_state_t state_q [NUM_BANKS];
  bank_state_t state_d [NUM_BANKS];

  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]     rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BANK_W:0]       full_count_q, full_count_d;
  logic                  dec_active_q, dec_active_d;
  logic [BANK_W-1:0]     dec_bank_q, dec_bank_d;
  logic                  avail_q, avail_d;
  logic                  frame_loaded_q;

  logic                  wr_fire, wr_last, wr_done;
  logic                  rel, acq, rd_fire, rd_in_range;
  logic [DATA_WIDTH-1:0] wr_data;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  // ---------------- input quantisation ----------------
`ifdef INT_MSG_SAT_EN
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;
  logic signed [IN_WIDTH-1:0] llr_s;
  assign llr_s   = $signed(in_llr);
  assign wr_data = (llr_s > SAT_HI) ? SAT_HI[DATA_WIDTH-1:0] :
                   (llr_s < SAT_LO) ? SAT_LO[DATA_WIDTH-1:0] :
                                      llr_s[DATA_WIDTH-1:0];
`else
  assign wr_data = in_llr[DATA_WIDTH-1:0];
  if (IN_WIDTH > DATA_WIDTH) begin : g_wrap
    logic unused_llr_hi;
    assign unused_llr_hi = ^in_llr[IN_WIDTH-1:DATA_WIDTH];
  end
`endif

  // ---------------- handshakes ----------------
  assign in_ready = (state_q[wr_bank_q] == ST_EMPTY) || (state_q[wr_bank_q] == ST_FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = (wr_addr_q == ADDR_WIDTH'(FRAME_LEN - 1));
  assign wr_done  = wr_fire && wr_last;
  assign rel      = dec_release && dec_active_q;
  // Release is applied first, so a same-cycle acquire sees the decoder idle.
  assign acq      = dec_acquire && avail_q && (!dec_active_q || rel);
  assign rd_fire  = dec_rd_en && dec_active_q;

  if (FRAME_LEN < 2 ** ADDR_WIDTH) begin : g_rng
    assign rd_in_range = (dec_rd_addr < ADDR_WIDTH'(FRAME_LEN));
  end else begin : g_full
    assign rd_in_range = 1'b1;
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_addr_d    = wr_addr_q;
    dec_active_d = dec_active_q;
    dec_bank_d   = dec_bank_q;
    full_count_d = full_count_q + {{BANK_W{1'b0}}, wr_done} - {{BANK_W{1'b0}}, acq};

    if (wr_fire) begin
      state_d[wr_bank_q] = wr_last ? ST_FULL : ST_FILLING;
      wr_addr_d          = wr_last ? '0 : wr_addr_q + ADDR_WIDTH'(1);
      if (wr_last) wr_bank_d = next_bank(wr_bank_q);
    end
    if (rel) begin
      state_d[dec_bank_q] = ST_EMPTY;
      dec_active_d        = 1'b0;
    end
    if (acq) begin
      state_d[rd_bank_q] = ST_DECODING;
      dec_active_d       = 1'b1;
      dec_bank_d         = rd_bank_q;
      rd_bank_d          = next_bank(rd_bank_q);
    end
    // Suppressed in the acquire cycle so the flag never points at a bank
    // that has just been claimed.
    avail_d = (state_q[rd_bank_q] == ST_FULL) && !acq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) state_q[i] <= ST_EMPTY;
      wr_bank_q      <= '0;
      rd_bank_q      <= '0;
      wr_addr_q      <= '0;
      full_count_q   <= '0;
      dec_active_q   <= 1'b0;
      dec_bank_q     <= '0;
      avail_q        <= 1'b0;
      frame_loaded_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_addr_q      <= wr_addr_d;
      full_count_q   <= full_count_d;
      dec_active_q   <= dec_active_d;
      dec_bank_q     <= dec_bank_d;
      avail_q        <= avail_d;
      frame_loaded_q <= wr_done;
    end
  end

  // ---------------- storage ----------------
  // Contents survive reset; the write and read banks are always distinct.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_addr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_rd_valid <= 1'b0;
      dec_rd_data  <= '0;
    end else begin
      dec_rd_valid <= rd_fire;
      if (rd_fire) dec_rd_data <= rd_in_range ? mem[dec_bank_q][dec_rd_addr] : '0;
    end
  end

  assign frame_loaded    = frame_loaded_q;
  assign dec_frame_avail = avail_q;
  assign dec_active      = dec_active_q;
  assign dec_bank        = dec_bank_q;
  assign full_count      = full_count_q;

endmodule

// File: tb/tb_int_msg_bank_buffer.sv
// Self-checking bench for int_msg_bank_buffer (default parameters, two banks).
module tb_int_msg_bank_buffer;
  localparam int DW = 5;
  localparam int IW = 8;
  localparam int AW = 8;
  localparam int FL = 256;
  localparam int NB = 2;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_llr = '0;
  logic          frame_loaded;
  logic          dec_frame_avail;
  logic          dec_acquire = 1'b0;
  logic          dec_active;
  logic [BW-1:0] dec_bank;
  logic          dec_release = 1'b0;
  logic          dec_rd_en = 1'b0;
  logic [AW-1:0] dec_rd_addr = '0;
  logic [DW-1:0] dec_rd_data;
  logic          dec_rd_valid;
  logic [BW:0]   full_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] model [NB][FL];
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  int_msg_bank_buffer #(
    .DATA_WIDTH(DW), .IN_WIDTH(IW), .ADDR_WIDTH(AW), .FRAME_LEN(FL), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .frame_loaded(frame_loaded), .dec_frame_avail(dec_frame_avail),
    .dec_acquire(dec_acquire), .dec_active(dec_active), .dec_bank(dec_bank),
    .dec_release(dec_release), .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
    .dec_rd_data(dec_rd_data), .dec_rd_valid(dec_rd_valid), .full_count(full_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] gen(input int kind, input int i);
    int v;
    if (kind == 0) v = (i % 16) - 8;
    else if (kind == 2 && i < 4) begin
      case (i)
        0: v = 100;
        1: v = -128;
        2: v = -16;
        default: v = 7;
      endcase
    end else v = ((i * 7 + kind * 29) % 256) - 128;
    return IW'(v);
  endfunction

  function automatic logic [DW-1:0] quant(input logic [IW-1:0] x);
`ifdef INT_MSG_SAT_EN
    int v;
    int lim;
    lim = (1 << (DW - 1)) - 1;
    v = $signed(x);
    if (v > lim) v = lim;
    if (v < -lim) v = -lim;
    return DW'(v);
`else
    return x[DW-1:0];
`endif
  endfunction

  task automatic load_frame(input int kind, input int bank, input int n,
                            output int pulses, output bit end_pulse, output bit ok);
    ok = 1'b1;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      int budget;
      budget = 0;
      in_valid = 1'b1;
      in_llr = gen(kind, i);
      while (!in_ready && budget < 2000) begin
        tick;
        budget++;
        if (frame_loaded) pulses++;
      end
      if (!in_ready) begin
        ok = 1'b0;
        break;
      end
      tick;
      model[bank][i] = quant(gen(kind, i));
      if (frame_loaded) pulses++;
    end
    in_valid = 1'b0;
    end_pulse = frame_loaded;
  endtask

  task automatic wait_avail(output bit ok);
    int budget;
    budget = 0;
    while (!dec_frame_avail && budget < 50) begin
      tick;
      budget++;
    end
    ok = dec_frame_avail;
  endtask

  task automatic pulse_acquire;
    dec_acquire = 1'b1;
    tick;
    dec_acquire = 1'b0;
  endtask

  task automatic pulse_release;
    dec_release = 1'b1;
    tick;
    dec_release = 1'b0;
  endtask

  task automatic read_check(input int bank, input int start, input int n, input bit rnd,
                            input string name);
    logic [DW-1:0] exp;
    for (int k = 0; k < n; k++) begin
      int addr;
      addr = rnd ? int'($urandom_range(0, FL - 1)) : start + k;
      dec_rd_en = 1'b1;
      dec_rd_addr = AW'(addr);
      sb_q.push_back(model[bank][addr]);
      tick;
      exp = sb_q.pop_front();
      total_cnt++;
      if (dec_rd_valid !== 1'b1 || dec_rd_data !== exp)
        $display("FAIL %s addr %0d: got valid=%0b data=%0h expected valid=1 data=%0h",
                 name, addr, dec_rd_valid, dec_rd_data, exp);
      else pass_cnt++;
    end
    dec_rd_en = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks every output before the next clock edge.
  task automatic test_reset(input string tag);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    dec_acquire = 1'b0;
    dec_release = 1'b0;
    dec_rd_en = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, frame_loaded, dec_frame_avail, dec_active, dec_rd_valid} !== 5'b10000)
      $display("FAIL %s_flags: got rdy/fl/av/act/vld=%b expected 10000", tag,
               {in_ready, frame_loaded, dec_frame_avail, dec_active, dec_rd_valid});
    else pass_cnt++;
    total_cnt++;
    if (dec_bank !== '0 || full_count !== '0 || dec_rd_data !== '0)
      $display("FAIL %s_values: got bank=%0d count=%0d data=%0h expected 0 0 0", tag,
               dec_bank, full_count, dec_rd_data);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    total_cnt++;
    if (in_ready !== 1'b1 || full_count !== '0)
      $display("FAIL %s_after: got in_ready=%0b count=%0d expected 1 0", tag, in_ready, full_count);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int p;
    bit ep, ok;
    logic [DW-1:0] exp;
    load_frame(0, 0, FL, p, ep, ok);
    total_cnt++;
    if (!ok || p != 1 || ep !== 1'b1)
      $display("FAIL basic_load: got ok=%0b pulses=%0d end=%0b expected 1 1 1", ok, p, ep);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (dec_frame_avail !== 1'b1 || frame_loaded !== 1'b0 || full_count !== 2'd1)
      $display("FAIL basic_avail: got avail=%0b fl=%0b count=%0d expected 1 0 1",
               dec_frame_avail, frame_loaded, full_count);
    else pass_cnt++;
    pulse_acquire;
    total_cnt++;
    if (dec_active !== 1'b1 || dec_bank !== 1'b0 || full_count !== 2'd0)
      $display("FAIL basic_acq: got act=%0b bank=%0d count=%0d expected 1 0 0",
               dec_active, dec_bank, full_count);
    else pass_cnt++;
    dec_rd_en = 1'b1;
    dec_rd_addr = AW'(10);
    sb_q.push_back(DW'(2));
    tick;
    dec_rd_en = 1'b0;
    exp = sb_q.pop_front();
    total_cnt++;
    if (dec_rd_valid !== 1'b1 || dec_rd_data !== exp)
      $display("FAIL basic_rd10: got valid=%0b data=%0h expected 1 %0h", dec_rd_valid, dec_rd_data, exp);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (dec_rd_valid !== 1'b0 || dec_rd_data !== DW'(2))
      $display("FAIL basic_hold: got valid=%0b data=%0h expected 0 2", dec_rd_valid, dec_rd_data);
    else pass_cnt++;
    read_check(0, 0, FL, 1'b0, "basic_rd");
    pulse_release;
    total_cnt++;
    if (dec_active !== 1'b0)
      $display("FAIL basic_rel: got act=%0b expected 0", dec_active);
    else pass_cnt++;
    dec_rd_en = 1'b1;
    tick;
    dec_rd_en = 1'b0;
    total_cnt++;
    if (dec_rd_valid !== 1'b0)
      $display("FAIL basic_rd_idle: got valid=%0b expected 0", dec_rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int p;
    bit ep, ok, stuck_low;
    load_frame(1, 0, FL, p, ep, ok);
    load_frame(3, 1, FL, p, ep, ok);
    total_cnt++;
    if (!ok || p != 1 || ep !== 1'b1 || in_ready !== 1'b0 || full_count !== 2'd2)
      $display("FAIL b2b_two: got ok=%0b pulses=%0d end=%0b rdy=%0b count=%0d expected 1 1 1 0 2",
               ok, p, ep, in_ready, full_count);
    else pass_cnt++;
    stuck_low = 1'b1;
    in_valid = 1'b1;
    in_llr = gen(4, 0);
    for (int k = 0; k < 6; k++) begin
      tick;
      if (in_ready !== 1'b0) stuck_low = 1'b0;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (stuck_low !== 1'b1 || full_count !== 2'd2)
      $display("FAIL b2b_stall: got stayed_low=%0b count=%0d expected 1 2", stuck_low, full_count);
    else pass_cnt++;
    pulse_acquire;
    total_cnt++;
    if (dec_bank !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL b2b_acq: got bank=%0d rdy=%0b expected 0 0", dec_bank, in_ready);
    else pass_cnt++;
    pulse_release;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_rel_ready: got %0b expected 1", in_ready);
    else pass_cnt++;
    load_frame(4, 0, FL, p, ep, ok);
    total_cnt++;
    if (!ok || p != 1 || full_count !== 2'd2)
      $display("FAIL b2b_third: got ok=%0b pulses=%0d count=%0d expected 1 1 2", ok, p, full_count);
    else pass_cnt++;
    wait_avail(ok);
    pulse_acquire;
    total_cnt++;
    if (!ok || dec_bank !== 1'b1)
      $display("FAIL b2b_order1: got avail_ok=%0b bank=%0d expected 1 1", ok, dec_bank);
    else pass_cnt++;
    read_check(1, 0, 16, 1'b1, "b2b_rd_f2");
    pulse_release;
    wait_avail(ok);
    pulse_acquire;
    total_cnt++;
    if (!ok || dec_bank !== 1'b0)
      $display("FAIL b2b_order2: got avail_ok=%0b bank=%0d expected 1 0", ok, dec_bank);
    else pass_cnt++;
    read_check(0, 0, FL, 1'b0, "b2b_rd_f3");
    pulse_release;
  endtask

  task automatic test_concurrent;
    int p;
    bit ep, ok, ready_ok;
    logic [DW-1:0] exp;
    load_frame(5, 0, FL, p, ep, ok);
    wait_avail(ok);
    pulse_acquire;
    total_cnt++;
    if (!ok || dec_bank !== 1'b0 || dec_active !== 1'b1)
      $display("FAIL conc_acq: got ok=%0b bank=%0d act=%0b expected 1 0 1", ok, dec_bank, dec_active);
    else pass_cnt++;
    ready_ok = 1'b1;
    for (int i = 0; i < FL; i++) begin
      int addr;
      addr = int'($urandom_range(0, FL - 1));
      in_valid = 1'b1;
      in_llr = gen(6, i);
      dec_rd_en = 1'b1;
      dec_rd_addr = AW'(addr);
      sb_q.push_back(model[0][addr]);
      if (in_ready !== 1'b1) ready_ok = 1'b0;
      tick;
      model[1][i] = quant(gen(6, i));
      exp = sb_q.pop_front();
      total_cnt++;
      if (dec_rd_valid !== 1'b1 || dec_rd_data !== exp)
        $display("FAIL conc_rd addr %0d: got valid=%0b data=%0h expected 1 %0h",
                 addr, dec_rd_valid, dec_rd_data, exp);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    dec_rd_en = 1'b0;
    total_cnt++;
    if (ready_ok !== 1'b1 || frame_loaded !== 1'b1 || dec_bank !== 1'b0)
      $display("FAIL conc_load: got ready_ok=%0b fl=%0b bank=%0d expected 1 1 0",
               ready_ok, frame_loaded, dec_bank);
    else pass_cnt++;
    pulse_release;
    wait_avail(ok);
    pulse_acquire;
    total_cnt++;
    if (!ok || dec_bank !== 1'b1)
      $display("FAIL conc_rot: got ok=%0b bank=%0d expected 1 1", ok, dec_bank);
    else pass_cnt++;
    read_check(1, 0, FL, 1'b0, "conc_rd_f2");
    pulse_release;
  endtask

  task automatic test_acq_rel;
    int p;
    bit ep, ok;
    load_frame(9, 0, FL, p, ep, ok);
    load_frame(10, 1, FL, p, ep, ok);
    tick;
    total_cnt++;
    if (full_count !== 2'd2 || dec_frame_avail !== 1'b1)
      $display("FAIL ar_two_full: got count=%0d avail=%0b expected 2 1", full_count, dec_frame_avail);
    else pass_cnt++;
    pulse_acquire;
    tick;
    total_cnt++;
    if (dec_bank !== 1'b0 || full_count !== 2'd1 || dec_frame_avail !== 1'b1)
      $display("FAIL ar_first: got bank=%0d count=%0d avail=%0b expected 0 1 1",
               dec_bank, full_count, dec_frame_avail);
    else pass_cnt++;
    pulse_acquire;
    total_cnt++;
    if (dec_bank !== 1'b0 || full_count !== 2'd1 || dec_active !== 1'b1)
      $display("FAIL ar_acq_ignored: got bank=%0d count=%0d act=%0b expected 0 1 1",
               dec_bank, full_count, dec_active);
    else pass_cnt++;
    dec_release = 1'b1;
    dec_acquire = 1'b1;
    tick;
    dec_release = 1'b0;
    dec_acquire = 1'b0;
    total_cnt++;
    if (dec_bank !== 1'b1 || dec_active !== 1'b1 || full_count !== 2'd0)
      $display("FAIL ar_same_cycle: got bank=%0d act=%0b count=%0d expected 1 1 0",
               dec_bank, dec_active, full_count);
    else pass_cnt++;
    read_check(1, 0, 8, 1'b1, "ar_rd");
    pulse_release;
    pulse_release;
    total_cnt++;
    if (dec_active !== 1'b0 || dec_bank !== 1'b1 || full_count !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL ar_rel_ignored: got act=%0b bank=%0d count=%0d rdy=%0b expected 0 1 0 1",
               dec_active, dec_bank, full_count, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_quant;
    int p;
    bit ep, ok;
    logic [DW-1:0] exp_tbl [4];
    logic [DW-1:0] exp;
`ifdef INT_MSG_SAT_EN
    exp_tbl[0] = DW'(15);
    exp_tbl[1] = DW'(-15);
    exp_tbl[2] = DW'(-15);
    exp_tbl[3] = DW'(7);
`else
    exp_tbl[0] = DW'(4);
    exp_tbl[1] = DW'(0);
    exp_tbl[2] = DW'(-16);
    exp_tbl[3] = DW'(7);
`endif
    load_frame(2, 0, FL, p, ep, ok);
    wait_avail(ok);
    pulse_acquire;
    for (int a = 0; a < 4; a++) begin
      dec_rd_en = 1'b1;
      dec_rd_addr = AW'(a);
      sb_q.push_back(exp_tbl[a]);
      tick;
      exp = sb_q.pop_front();
      total_cnt++;
      if (dec_rd_valid !== 1'b1 || dec_rd_data !== exp)
        $display("FAIL quant addr %0d: got valid=%0b data=%0h expected 1 %0h",
                 a, dec_rd_valid, dec_rd_data, exp);
      else pass_cnt++;
    end
    dec_rd_en = 1'b0;
    pulse_release;
  endtask

  task automatic test_reset_mid;
    int p;
    bit ep, ok;
    load_frame(7, 0, 100, p, ep, ok);
    total_cnt++;
    if (!ok || p != 0)
      $display("FAIL rm_partial: got ok=%0b pulses=%0d expected 1 0", ok, p);
    else pass_cnt++;
    in_valid = 1'b1;
    in_llr = gen(7, 100);
    test_reset("rst_midframe");
    load_frame(11, 0, FL, p, ep, ok);
    wait_avail(ok);
    pulse_acquire;
    read_check(0, 0, 4, 1'b1, "rm_pre_rd");
    dec_rd_en = 1'b1;
    dec_rd_addr = AW'(3);
    test_reset("rst_middecode");
    load_frame(12, 0, FL, p, ep, ok);
    wait_avail(ok);
    pulse_acquire;
    total_cnt++;
    if (!ok || dec_bank !== 1'b0 || dec_active !== 1'b1)
      $display("FAIL rm_reload: got ok=%0b bank=%0d act=%0b expected 1 0 1", ok, dec_bank, dec_active);
    else pass_cnt++;
    read_check(0, 0, FL, 1'b0, "rm_rd");
    pulse_release;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    test_reset("rst_init");
    test_basic;
    test_reset("rst_b2b");
    test_back_to_back;
    test_reset("rst_conc");
    test_concurrent;
    test_reset("rst_ar");
    test_acq_rel;
    test_reset("rst_quant");
    test_quant;
    test_reset("rst_mid");
    test_reset_mid;
    total_cnt++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
